calc1_quad_core: RTL and testbench
==================================

Name: calc1_quad_core

Overview:
- Four-port 32-bit integer calculator; each request port issues add/subtract/shift commands independently and gets its own response/data pair.
- Top-level compute block; a test environment or system bus drives it directly.
- Ports are symmetric, with no cross-port interaction.

Parameters:
- NUM_PORTS, 4, number of request/response port pairs; fixed at 4 (port list below is explicit).
- DATA_W, 32, operand/result width.

Ports:
- c_clk  input  1  single clock; all logic on rising edge.
- reset  input  7  asynchronous, active-high reset; block is held in reset while any bit is 1.
- reqN_cmd_in (N=1..4)  input  4  command for port N; sampled only when port N is idle.
- reqN_data_in (N=1..4)  input  32  operand 1 in the command cycle, operand 2 in the following cycle.
- out_respN (N=1..4)  output  2  response code for port N.
- out_dataN (N=1..4)  output  32  result for port N.

Behaviour:
- Reset (async assert, sync release): all out_respN=0, out_dataN=0, all port pipelines idle, in-flight commands discarded with no response. Bench holds reset=7'b1111111 for 7 cycles before traffic.
- Commands:
  - 0 no-op.
  - 1 add: op1+op2.
  - 2 subtract: op1-op2.
  - 5 shift left: op1<<op2[4:0].
  - 6 shift right, logical: op1>>op2[4:0].
  - All other codes (3,4,7..15) are invalid.
- Response codes:
  - 00 no response.
  - 01 success.
  - 10 overflow/underflow/invalid command.
  - 11 reserved, never driven.
- Timing per port, command sampled non-zero at edge k:
  - edge k: op1 captured from reqN_data_in.
  - edge k+1: op2 captured; cmd input ignored at this edge.
  - edge k+2: result and response registered onto outputs.
  - edge k+3: outputs return to resp=00, data=0.
- Response is a one-cycle pulse. Issue interval is 2 cycles: next command may be sampled at edge k+2, giving back-to-back responses at k+2, k+4, ...
- Command 0 at an idle edge: nothing captured, no response.
- out_dataN is 0 whenever out_respN != 01.
- Add: 33-bit sum; carry out -> resp 10, data 0. Else resp 01, data = sum[31:0].
- Subtract: op2 > op1 -> underflow, resp 10, data 0. Else resp 01, data = op1-op2. Equal operands give data 0, resp 01.
- Shifts: only op2[4:0] used, upper bits ignored; always resp 01. Shift by 0 returns op1. Bits shifted out are lost; no overflow reported.
- Invalid command: op2 cycle still consumed; resp 10, data 0 at edge k+2.
- All four ports may respond in the same cycle; no arbitration, no shared-resource stalls.
- Reset asserted mid-operation: affected commands produce no response; outputs go to 0 immediately (async).

Decomposition:
- Shared package calc1_pkg:
  - command code constants CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6.
  - response constants RESP_NONE=0, RESP_OK=1, RESP_ERR=2.
  - DATA_W.
- One sub-module, calc1_port: per-port capture FSM (IDLE -> OPERAND2 -> IDLE, result register written on OPERAND2 exit) plus ALU. Instantiated 4 times in the top.

Test Plan:
- Reset: reset=7'h7F for 7 cycles, then 0 -> all out_respN=0, out_dataN=0; a command issued during reset gives no response.
- Port 1 add: cmd=1, data=32'h5 then 32'h7 -> two edges later out_resp1=01, out_data1=32'hC for exactly one cycle. Add FFFFFFFF+1 -> resp 10, data 0.
- Port 2 subtract: 10-3 -> resp 01, data 7; 5-5 -> resp 01, data 0; 3-10 -> resp 10, data 0.
- Port 3 shifts: cmd=5, 32'h1 by 31 -> 32'h80000000 resp 01. cmd=6, 32'h80000000 by 32'h24 (low 5 bits = 4) -> 32'h08000000 resp 01.
- Port 4 invalid: cmd=3 with data 1,1 -> resp 10, data 0; cmd=0 -> no response. Then back-to-back adds at 2-cycle spacing -> responses on consecutive 2-cycle slots.
- Concurrency: all four ports issue different valid commands on the same edge -> all four correct responses in the same cycle. Reset pulsed at op2 edge -> no responses, outputs 0.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared definitions for the quad-port calculator: command/response codes, widths, ALU.
// Latency: n/a (package).
// Backpressure: n/a (package).
package calc1_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_PORTS = 4;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } port_state_t;

  typedef struct packed {
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
  } result_t;

  // Single-cycle ALU. Every error outcome carries zero data so the output
  // stage never has to mask anything.
  function automatic result_t alu(input logic [3:0]        cmd,
                                  input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
    result_t         r;
    logic [DATA_W:0] sum;
    r.resp = RESP_ERR;
    r.data = '0;
    sum    = {1'b0, a} + {1'b0, b};
    case (cmd)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          r.resp = RESP_OK;
          r.data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (b <= a) begin
          r.resp = RESP_OK;
          r.data = a - b;
        end
      end
      CMD_SHL: begin
        r.resp = RESP_OK;
        r.data = a << b[4:0];
      end
      CMD_SHR: begin
        r.resp = RESP_OK;
        r.data = a >> b[4:0];
      end
      default: begin
        r.resp = RESP_ERR;
        r.data = '0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc1_port.sv
// One calculator port: captures op1 on the command edge, op2 on the next, then emits a one-cycle response.
// Latency: response registered two edges after the command edge; issue interval two cycles.
// Backpressure: none; cmd is ignored while op2 is being captured, responses are never stalled.
module calc1_port
  import calc1_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_cmd,
  input  logic [DATA_W-1:0] i_data,
  output logic [1:0]        o_resp,
  output logic [DATA_W-1:0] o_data
);

  port_state_t       r_state;
  port_state_t       w_next;
  logic [3:0]        r_cmd;
  logic [DATA_W-1:0] r_op1;
  result_t           r_res;
  logic              r_res_vld;
  logic [1:0]        r_resp;
  logic [DATA_W-1:0] r_data;
  result_t           w_alu;
  logic              w_start;

  // op2 is consumed straight from the input bus on the OP2 edge
  assign w_alu   = alu(r_cmd, r_op1, i_data);
  assign w_start = (r_state == ST_IDLE) && (i_cmd != CMD_NOP);

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // next-state: a non-zero command starts a two-cycle capture
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_OP2;
      ST_OP2:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // operand capture and result staging on OP2 exit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd     <= CMD_NOP;
      r_op1     <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
    end else begin
      r_res_vld <= (r_state == ST_OP2);
      if (w_start) begin
        r_cmd <= i_cmd;
        r_op1 <= i_data;
      end
      if (r_state == ST_OP2) r_res <= w_alu;
    end
  end

  // output register: one-cycle response pulse, zero otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_resp <= RESP_NONE;
      r_data <= '0;
    end else begin
      r_resp <= r_res_vld ? r_res.resp : RESP_NONE;
      r_data <= r_res_vld ? r_res.data : '0;
    end
  end

  assign o_resp = r_resp;
  assign o_data = r_data;

endmodule

// File: rtl/calc1_quad_core.sv
// Four independent 32-bit add/sub/shift calculator ports sharing only clock and reset.
// Latency: response two edges after the command edge on each port; ports never interact.
// Backpressure: none; all four ports may respond in the same cycle.
module calc1_quad_core
  import calc1_pkg::*;
(
  input  logic              c_clk,
  input  logic [6:0]        reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4
);

  // any reset bit holds the whole block in reset
  logic              w_rst;
  logic [3:0]        w_cmd  [NUM_PORTS];
  logic [DATA_W-1:0] w_din  [NUM_PORTS];
  logic [1:0]        w_resp [NUM_PORTS];
  logic [DATA_W-1:0] w_dout [NUM_PORTS];

  assign w_rst = |reset;

  assign w_cmd[0] = req1_cmd_in;
  assign w_cmd[1] = req2_cmd_in;
  assign w_cmd[2] = req3_cmd_in;
  assign w_cmd[3] = req4_cmd_in;
  assign w_din[0] = req1_data_in;
  assign w_din[1] = req2_data_in;
  assign w_din[2] = req3_data_in;
  assign w_din[3] = req4_data_in;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    calc1_port u_port (
      .i_clk  (c_clk),
      .i_rst  (w_rst),
      .i_cmd  (w_cmd[g]),
      .i_data (w_din[g]),
      .o_resp (w_resp[g]),
      .o_data (w_dout[g])
    );
  end

  assign out_resp1 = w_resp[0];
  assign out_resp2 = w_resp[1];
  assign out_resp3 = w_resp[2];
  assign out_resp4 = w_resp[3];
  assign out_data1 = w_dout[0];
  assign out_data2 = w_dout[1];
  assign out_data3 = w_dout[2];
  assign out_data4 = w_dout[3];

endmodule

// File: tb/tb_calc1_quad_core.sv
// Scoreboard bench for calc1_quad_core: directed cases plus randomized traffic on all four ports.
// Expected responses are queued at issue time and checked by an independent monitor each cycle.
// Reset both at start and mid-operation flushes the scoreboard.
module tb_calc1_quad_core;

  typedef struct {
    int          due;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        c_clk;
  logic [6:0]  reset;
  logic [3:0]  cmd  [4];
  logic [31:0] din  [4];
  logic [1:0]  resp [4];
  logic [31:0] dout [4];

  logic [3:0]  s_cmd [4];
  logic [31:0] s_a   [4];
  logic [31:0] s_b   [4];
  logic [3:0]  vcmd  [4];

  exp_t sb [4][$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic [1:0]  er;
  logic [31:0] ed;

  calc1_quad_core dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd[0]),
    .req2_cmd_in  (cmd[1]),
    .req3_cmd_in  (cmd[2]),
    .req4_cmd_in  (cmd[3]),
    .req1_data_in (din[0]),
    .req2_data_in (din[1]),
    .req3_data_in (din[2]),
    .req4_data_in (din[3]),
    .out_resp1    (resp[0]),
    .out_resp2    (resp[1]),
    .out_resp3    (resp[2]),
    .out_resp4    (resp[3]),
    .out_data1    (dout[0]),
    .out_data2    (dout[1]),
    .out_data3    (dout[2]),
    .out_data4    (dout[3])
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  always @(posedge c_clk) cyc <= cyc + 1;

  // Reference model: the calculator's arithmetic rules in plain terms.
  function automatic exp_t model(input int due, input logic [3:0] c,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        m;
    logic [63:0] s;
    m.due  = due;
    m.resp = 2'd2;
    m.data = 32'd0;
    s      = {32'd0, a} + {32'd0, b};
    case (c)
      4'd1: if (s <= 64'h0000_0000_FFFF_FFFF) begin m.resp = 2'd1; m.data = s[31:0]; end
      4'd2: if (a >= b) begin m.resp = 2'd1; m.data = a - b; end
      4'd5: begin m.resp = 2'd1; m.data = a << (b % 32); end
      4'd6: begin m.resp = 2'd1; m.data = a >> (b % 32); end
      default: ;
    endcase
    return m;
  endfunction

  // Monitor: every cycle each port must show either its due response or idle zeros.
  always @(negedge c_clk) begin
    for (int p = 0; p < 4; p++) begin
      er = 2'd0;
      ed = 32'd0;
      if (reset == 7'd0 && sb[p].size() > 0 && sb[p][0].due == cyc) begin
        er = sb[p][0].resp;
        ed = sb[p][0].data;
        void'(sb[p].pop_front());
      end
      total++;
      if (resp[p] !== er || dout[p] !== ed) begin
        bad++;
        $display("FAIL port%0d cyc=%0d got resp=%0d data=%h want resp=%0d data=%h",
                 p + 1, cyc, resp[p], dout[p], er, ed);
      end
    end
  end

  task automatic clr();
    for (int p = 0; p < 4; p++) begin
      s_cmd[p] = 4'd0;
      s_a[p]   = $urandom;
      s_b[p]   = $urandom;
    end
  endtask

  task automatic set_p(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    s_cmd[p] = c;
    s_a[p]   = a;
    s_b[p]   = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge c_clk); #1;
      for (int p = 0; p < 4; p++) begin
        cmd[p] = 4'd0;
        din[p] = $urandom;
      end
    end
  endtask

  // Two-cycle command slot; junk on cmd during the op2 cycle must be ignored.
  task automatic slot(input bit rst_at_op2);
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = s_cmd[p];
      din[p] = s_a[p];
      if (s_cmd[p] != 4'd0) sb[p].push_back(model(cyc + 3, s_cmd[p], s_a[p], s_b[p]));
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = (s_cmd[p] != 4'd0) ? 4'($urandom) : 4'd0;
      din[p] = s_b[p];
    end
    if (rst_at_op2) begin
      reset = 7'h40;
      for (int p = 0; p < 4; p++) sb[p].delete();
      @(posedge c_clk); #1;
      reset = 7'd0;
      for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
    end
  endtask

  initial begin
    vcmd[0] = 4'd1; vcmd[1] = 4'd2; vcmd[2] = 4'd5; vcmd[3] = 4'd6;
    reset = 7'h7F;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd1;
      din[p] = 32'h1234;
    end
    repeat (7) @(posedge c_clk);
    #1;
    reset = 7'd0;
    for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
    idle(3);

    clr(); set_p(0, 4'd1, 32'h5, 32'h7);          slot(0); idle(2);
    clr(); set_p(0, 4'd1, 32'hFFFF_FFFF, 32'h1);  slot(0); idle(2);
    clr(); set_p(1, 4'd2, 32'd10, 32'd3);         slot(0);
    clr(); set_p(1, 4'd2, 32'd5, 32'd5);          slot(0);
    clr(); set_p(1, 4'd2, 32'd3, 32'd10);         slot(0); idle(2);
    clr(); set_p(2, 4'd5, 32'h1, 32'd31);         slot(0);
    clr(); set_p(2, 4'd6, 32'h8000_0000, 32'h24); slot(0); idle(2);
    clr(); set_p(3, 4'd3, 32'h1, 32'h1);          slot(0);
    clr();                                        slot(0);
    for (int i = 0; i < 3; i++) begin
      clr(); set_p(3, 4'd1, 32'(i * 100), 32'd7); slot(0);
    end
    idle(2);
    clr();
    set_p(0, 4'd1, 32'd40, 32'd2);
    set_p(1, 4'd2, 32'd40, 32'd2);
    set_p(2, 4'd5, 32'd40, 32'd2);
    set_p(3, 4'd6, 32'd40, 32'd2);
    slot(0); idle(3);
    clr();
    for (int p = 0; p < 4; p++) set_p(p, vcmd[p], 32'hABCD, 32'd1);
    slot(1); idle(4);

    for (int i = 0; i < 250; i++) begin
      clr();
      for (int p = 0; p < 4; p++) begin
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        case ($urandom_range(0, 3))
          0: b = $urandom;
          1: b = a;
          2: b = $urandom_range(0, 64);
          default: b = ~a + 32'($urandom_range(0, 2));
        endcase
        if ($urandom_range(0, 3) == 0) set_p(p, 4'($urandom_range(0, 15)), a, b);
        else                           set_p(p, vcmd[$urandom_range(0, 3)], a, b);
      end
      slot(0);
      if ($urandom_range(0, 4) == 0) idle(1);
    end

    idle(6);
    for (int p = 0; p < 4; p++) begin
      total++;
      if (sb[p].size() != 0) begin
        bad++;
        $display("FAIL drain port%0d pending=%0d want 0", p + 1, sb[p].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
